icb_buffer_ost: RTL

- Next-generation ICB slice buffer: parametrised command and response FIFOs between an upstream master port (i_icb_*) and a downstream slave port (o_icb_*).
- Adds behaviour the plain buffer lacks: a hard outstanding-transaction limit, a quiesce/drain handshake for clock-gating and power-down, and detection and dropping of spurious downstream responses with a sticky error flag.
- Sits at bus-fabric boundaries in front of peripherals and memories.

---
 rtl/icb_buffer_ost.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/icb_buffer_ost.sv
// ICB slice buffer with command/response FIFOs, an outstanding-transaction limit,
// a quiesce/drain handshake and dropping of spurious downstream responses.
module icb_buffer_ost #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned USR_W         = 1,
  parameter int unsigned CMD_DP        = 2,
  parameter int unsigned RSP_DP        = 2,
  parameter int unsigned CMD_CUT_READY = 0,
  parameter int unsigned RSP_CUT_READY = 0,
  parameter int unsigned MAX_OUTS      = 4,
  parameter int unsigned OUTS_CNT_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_icb_cmd_valid,
  output logic                  i_icb_cmd_ready,
  input  logic                  i_icb_cmd_read,
  input  logic [AW-1:0]         i_icb_cmd_addr,
  input  logic [DW-1:0]         i_icb_cmd_wdata,
  input  logic [DW/8-1:0]       i_icb_cmd_wmask,
  input  logic [1:0]            i_icb_cmd_size,
  input  logic [USR_W-1:0]      i_icb_cmd_usr,

  output logic                  i_icb_rsp_valid,
  input  logic                  i_icb_rsp_ready,
  output logic                  i_icb_rsp_err,
  output logic [DW-1:0]         i_icb_rsp_rdata,
  output logic [USR_W-1:0]      i_icb_rsp_usr,

  output logic                  o_icb_cmd_valid,
  input  logic                  o_icb_cmd_ready,
  output logic                  o_icb_cmd_read,
  output logic [AW-1:0]         o_icb_cmd_addr,
  output logic [DW-1:0]         o_icb_cmd_wdata,
  output logic [DW/8-1:0]       o_icb_cmd_wmask,
  output logic [1:0]            o_icb_cmd_size,
  output logic [USR_W-1:0]      o_icb_cmd_usr,

  input  logic                  o_icb_rsp_valid,
  output logic                  o_icb_rsp_ready,
  input  logic                  o_icb_rsp_err,
  input  logic [DW-1:0]         o_icb_rsp_rdata,
  input  logic [USR_W-1:0]      o_icb_rsp_usr,

  input  logic                  quiesce_req,
  output logic                  quiesce_ack,
  output logic                  busy,
  output logic [OUTS_CNT_W-1:0] outs_cnt,
  output logic                  err_spurious,
  input  logic                  err_clr
);

  localparam int unsigned CmdW = 1 + AW + DW + DW / 8 + 2 + USR_W;
  localparam int unsigned RspW = 1 + DW + USR_W;
  localparam logic [OUTS_CNT_W-1:0] MaxOuts = OUTS_CNT_W'(MAX_OUTS);

  logic [OUTS_CNT_W-1:0] outs_cnt_q, outs_cnt_d;
  logic [OUTS_CNT_W-1:0] dn_cnt_q, dn_cnt_d;
  logic                  err_q, err_d;

  logic            cmd_gate, cmd_wr_vld, cmd_wr_rdy, cmd_rd_vld, cmd_empty;
  logic [CmdW-1:0] cmd_wdat, cmd_rdat;
  logic            rsp_wr_vld, rsp_wr_rdy, rsp_rd_vld, rsp_empty;
  logic [RspW-1:0] rsp_wdat, rsp_rdat;
  logic            dn_zero, spurious;

  // Gate uses the registered count so a same-cycle response cannot reopen it.
  assign cmd_gate        = ~quiesce_req & (outs_cnt_q < MaxOuts);
  assign cmd_wr_vld      = i_icb_cmd_valid & cmd_gate;
  assign i_icb_cmd_ready = cmd_wr_rdy & cmd_gate;
  assign cmd_wdat        = {i_icb_cmd_read, i_icb_cmd_addr, i_icb_cmd_wdata,
                            i_icb_cmd_wmask, i_icb_cmd_size, i_icb_cmd_usr};
  assign {o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata,
          o_icb_cmd_wmask, o_icb_cmd_size, o_icb_cmd_usr} = cmd_rdat;
  assign o_icb_cmd_valid = cmd_rd_vld;

  if (CMD_DP == 0) begin : g_cmd_wire
    assign cmd_rd_vld = cmd_wr_vld & rst;
    assign cmd_wr_rdy = o_icb_cmd_ready;
    assign cmd_rdat   = cmd_wdat;
    assign cmd_empty  = 1'b1;
  end else begin : g_cmd_fifo
    localparam int unsigned PW = (CMD_DP > 1) ? $clog2(CMD_DP) : 1;
    localparam int unsigned CW = $clog2(CMD_DP + 1);
    logic [CmdW-1:0] mem_q [CMD_DP];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic            push, pop, full;

    assign full       = (cnt_q == CW'(CMD_DP));
    assign cmd_rd_vld = (cnt_q != '0);
    assign cmd_empty  = (cnt_q == '0);
    assign pop        = cmd_rd_vld & o_icb_cmd_ready;
    // Without the cut, a full FIFO may accept a push in the cycle it pops.
    assign cmd_wr_rdy = ~full | ((CMD_CUT_READY == 0) & o_icb_cmd_ready);
    assign push       = cmd_wr_vld & cmd_wr_rdy;
    assign cmd_rdat   = mem_q[rptr_q];

    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= cmd_wdat;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= (wptr_q == PW'(CMD_DP - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_q <= (rptr_q == PW'(CMD_DP - 1)) ? '0 : rptr_q + 1'b1;
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign dn_zero         = (dn_cnt_q == '0);
  assign rsp_wr_vld      = o_icb_rsp_valid & ~dn_zero;
  // With nothing pending the beat is swallowed, so never stall it.
  assign o_icb_rsp_ready = rsp_wr_rdy | dn_zero;
  assign spurious        = o_icb_rsp_valid & dn_zero;
  assign rsp_wdat        = {o_icb_rsp_err, o_icb_rsp_rdata, o_icb_rsp_usr};
  assign {i_icb_rsp_err, i_icb_rsp_rdata, i_icb_rsp_usr} = rsp_rdat;
  assign i_icb_rsp_valid = rsp_rd_vld;

  if (RSP_DP == 0) begin : g_rsp_wire
    assign rsp_rd_vld = rsp_wr_vld & rst;
    assign rsp_wr_rdy = i_icb_rsp_ready;
    assign rsp_rdat   = rsp_wdat;
    assign rsp_empty  = 1'b1;
  end else begin : g_rsp_fifo
    localparam int unsigned PW = (RSP_DP > 1) ? $clog2(RSP_DP) : 1;
    localparam int unsigned CW = $clog2(RSP_DP + 1);
    logic [RspW-1:0] mem_q [RSP_DP];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic            push, pop, full;

    assign full       = (cnt_q == CW'(RSP_DP));
    assign rsp_rd_vld = (cnt_q != '0);
    assign rsp_empty  = (cnt_q == '0);
    assign pop        = rsp_rd_vld & i_icb_rsp_ready;
    assign rsp_wr_rdy = ~full | ((RSP_CUT_READY == 0) & i_icb_rsp_ready);
    assign push       = rsp_wr_vld & rsp_wr_rdy;
    assign rsp_rdat   = mem_q[rptr_q];

    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= rsp_wdat;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wptr_q <= (wptr_q == PW'(RSP_DP - 1)) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_q <= (rptr_q == PW'(RSP_DP - 1)) ? '0 : rptr_q + 1'b1;
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_comb begin
    logic up_inc, up_dec, dn_inc, dn_dec;
    up_inc     = i_icb_cmd_valid & i_icb_cmd_ready;
    up_dec     = i_icb_rsp_valid & i_icb_rsp_ready;
    dn_inc     = o_icb_cmd_valid & o_icb_cmd_ready;
    dn_dec     = rsp_wr_vld & rsp_wr_rdy;
    outs_cnt_d = outs_cnt_q;
    dn_cnt_d   = dn_cnt_q;
    err_d      = err_q;
    if (up_inc && !up_dec && outs_cnt_q != MaxOuts) outs_cnt_d = outs_cnt_q + 1'b1;
    else if (!up_inc && up_dec && outs_cnt_q != '0) outs_cnt_d = outs_cnt_q - 1'b1;
    if (dn_inc && !dn_dec)      dn_cnt_d = dn_cnt_q + 1'b1;
    else if (!dn_inc && dn_dec) dn_cnt_d = dn_cnt_q - 1'b1;
    if (spurious)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs_cnt_q <= '0;
      dn_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      outs_cnt_q <= outs_cnt_d;
      dn_cnt_q   <= dn_cnt_d;
      err_q      <= err_d;
    end
  end

  assign quiesce_ack  = quiesce_req & cmd_empty & rsp_empty & (outs_cnt_q == '0) & dn_zero;
  assign busy         = i_icb_cmd_valid | (outs_cnt_q != '0);
  assign outs_cnt     = outs_cnt_q;
  assign err_spurious = err_q;

endmodule
